param_interval_timer: RTL and testbench
=======================================

PARAM_INTERVAL_TIMER -- requirements
Module: param_interval_timer

Interface
REQ-001 Parameter COUNT_W, default 32, meaning counter width; legal range 17..32.
REQ-002 Parameter RESET_PERIOD, default 32'd49999, meaning period and counter value after reset; truncated to COUNT_W bits.
REQ-003 Port clk input 1 bit, system clock; all state updates on its rising edge.
REQ-004 Port reset_n input 1 bit, asynchronous active-low reset.
REQ-005 Port chipselect input 1 bit, slave select.
REQ-006 Port address input 3 bits, register index 0..7.
REQ-007 Port write_n input 1 bit, active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-008 Port writedata input 16 bits, write data.
REQ-009 Port readdata output 16 bits, registered read data.
REQ-010 Port irq output 1 bit, level interrupt equal to TO AND ITO.

Function
REQ-011 Register map SHALL be: 0 STATUS {bit1 RUN, bit0 TO}; 1 CONTROL {bit3 STOP, bit2 START, bit1 CONT, bit0 ITO}; 2 PERIODL; 3 PERIODH; 4 SNAPL; 5 SNAPH; 6..7 reserved, read 0, writes ignored.
REQ-012 readdata SHALL present the addressed register one cycle after the address is applied, independent of chipselect.
REQ-013 PERIOD SHALL be COUNT_W bits: PERIODL holds bits 15:0, PERIODH holds bits COUNT_W-1:16; unused upper read bits SHALL be 0.
REQ-014 Writing PERIODL or PERIODH SHALL update that half, clear RUN, and load the counter with the new full period on the following cycle.
REQ-015 While RUN=1 the counter SHALL decrement by 1 per cycle; it SHALL hold when RUN=0.
REQ-016 When the counter is 0 with RUN=1, the next cycle SHALL reload PERIOD and set TO; RUN SHALL remain 1 if CONT=1 and clear to 0 if CONT=0 (one-shot).
REQ-017 The timeout interval SHALL be PERIOD+1 cycles; PERIOD=0 SHALL produce a timeout every cycle when CONT=1.
REQ-018 A CONTROL write SHALL store ITO and CONT; START=1 SHALL set RUN; STOP=1 SHALL clear RUN; if both are 1, STOP SHALL win.
REQ-019 START and STOP SHALL be self-clearing and read as 0.
REQ-020 Any write to STATUS SHALL clear TO; a timeout in the same cycle SHALL take priority and leave TO=1.
REQ-021 A START write while running SHALL NOT reload the counter.
REQ-022 A START write in the cycle a period write's reload takes effect SHALL leave RUN=1 and the counter equal to the new PERIOD.
REQ-023 irq SHALL be combinational from registered TO and ITO, with no additional delay.

Reset
REQ-024 Asserting reset_n low SHALL immediately set: counter=RESET_PERIOD, PERIOD=RESET_PERIOD, RUN=0, TO=0, ITO=0, CONT=0, snapshot=0, readdata=0, irq=0.
REQ-025 Reset asserted mid-count SHALL discard all state; after release the timer SHALL stay idle until START.
REQ-026 Deassertion SHALL be used synchronously; the first counter decrement SHALL occur no earlier than the cycle after the first START write.

Configuration
REQ-027 With macro TIMER_SNAPSHOT_EN defined, a write to SNAPL or SNAPH SHALL copy the current counter into the snapshot register.
REQ-028 With TIMER_SNAPSHOT_EN defined, SNAPL and SNAPH SHALL return the snapshot's low and high halves and SHALL hold their value until the next snapshot write.
REQ-029 Without TIMER_SNAPSHOT_EN, addresses 4..5 SHALL read 0, writes to them SHALL be ignored, and no snapshot storage SHALL be synthesised.

Verification
REQ-030 Reset, write PERIODL=4, PERIODH=0, CONTROL=0x7 (START|CONT|ITO) -> TO and irq rise every 5 cycles; RUN stays 1.
REQ-031 PERIOD=9, CONTROL=0x4 (one-shot) -> exactly one TO after 10 cycles; RUN=0; counter held at 9.
REQ-032 TO=1 with STATUS write coinciding with the next timeout (PERIOD=2, CONT=1) -> TO remains 1; a STATUS write in a later non-timeout cycle -> TO=0, irq=0.
REQ-033 CONTROL=0xC (START|STOP) while idle -> RUN stays 0; counter unchanged.
REQ-034 COUNT_W=32, PERIOD=0x0001_0003, running; write SNAPL at a known cycle -> SNAPH:SNAPL equals the expected counter value; with TIMER_SNAPSHOT_EN undefined -> both read 0.
REQ-035 Assert reset_n low mid-count with irq=1 -> irq, RUN and readdata go to 0 immediately without a clock edge; counter reads back RESET_PERIOD.

Source files
------------

// File: rtl/param_interval_timer_if.sv
// param_interval_timer_if -- register bus between a host and the interval timer.
//
// Bus semantics: a write is accepted on the rising clk edge where
// chipselect=1 and write_n=0. There is no wait state and no ready signal, so
// every qualified write lands in that cycle. readdata is registered. It
// presents the register selected by address one cycle after the address is
// applied, regardless of chipselect. irq is a level that stays high while the
// timeout flag and its enable are both set.
interface param_interval_timer_if;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    // Host side: drives the bus, observes read data and the interrupt.
    modport master (
        output chipselect,
        output address,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    // Timer side: decodes the bus, returns read data and the interrupt.
    modport slave (
        input  chipselect,
        input  address,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/param_interval_timer.sv
// param_interval_timer -- programmable down-counting interval timer.
//
// Register map (16-bit data, 3-bit address):
//   0 STATUS  {RUN, TO}           any write clears TO
//   1 CONTROL {STOP, START, CONT, ITO}   START/STOP are strobes, read as 0
//   2 PERIODL period[15:0]
//   3 PERIODH period[COUNT_W-1:16]
//   4 SNAPL   snapshot[15:0]      (only with TIMER_SNAPSHOT_EN)
//   5 SNAPH   snapshot[COUNT_W-1:16]
//   6..7      reserved, read 0
//
// Optional feature: define TIMER_SNAPSHOT_EN to build the counter snapshot
// register. Without it, addresses 4..5 read 0 and no snapshot storage exists.
//
// The counter counts PERIOD down to 0. It reloads PERIOD on the cycle after
// it reaches 0, so one interval is PERIOD+1 cycles.
module param_interval_timer #(
    parameter int          COUNT_W      = 32,
    parameter logic [31:0] RESET_PERIOD = 32'd49999
) (
    input  logic                   clk,
    input  logic                   reset_n,
    param_interval_timer_if.slave  bus
);

    localparam int                 HI_W       = COUNT_W - 16;
    localparam logic [COUNT_W-1:0] RST_PERIOD = RESET_PERIOD[COUNT_W-1:0];
    localparam logic [COUNT_W-1:0] ONE        = {{(COUNT_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    // Architectural state
    logic [COUNT_W-1:0] counter;
    logic [COUNT_W-1:0] period;
    logic               run;
    logic               to;
    logic               cont;
    logic               ito;
    logic               reload_pending;

    // Decoded bus strobes
    logic wr;
    logic wr_status;
    logic wr_control;
    logic wr_periodl;
    logic wr_periodh;
    logic ctrl_start;
    logic ctrl_stop;
    logic timeout;

    logic [15:0] snap_lo;
    logic [15:0] snap_hi;
    logic [15:0] read_mux;

    // Decode the write strobe per register and the timeout condition.
    always_comb begin
        wr         = bus.chipselect & ~bus.write_n;
        wr_status  = wr && (bus.address == ADDR_STATUS);
        wr_control = wr && (bus.address == ADDR_CONTROL);
        wr_periodl = wr && (bus.address == ADDR_PERIODL);
        wr_periodh = wr && (bus.address == ADDR_PERIODH);
        ctrl_start = bus.writedata[2];
        ctrl_stop  = bus.writedata[3];
        timeout    = run && (counter == '0);
    end

    // Period halves. A write to either half schedules a reload of the full
    // period on the next cycle, once both the new half and the old half are
    // visible together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period         <= RST_PERIOD;
            reload_pending <= 1'b0;
        end else begin
            if (wr_periodl) begin
                period[15:0] <= bus.writedata;
            end
            if (wr_periodh) begin
                period[COUNT_W-1:16] <= bus.writedata[HI_W-1:0];
            end
            reload_pending <= wr_periodl | wr_periodh;
        end
    end

    // Down counter: a pending period reload wins. A timeout reloads, and the
    // counter otherwise decrements only while running. A START never touches
    // the counter, so restarting after STOP resumes where it left off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= RST_PERIOD;
        end else if (reload_pending) begin
            counter <= period;
        end else if (timeout) begin
            counter <= period;
        end else if (run) begin
            counter <= counter - ONE;
        end
    end

    // RUN flag. A period write stops the timer. On a CONTROL write STOP beats
    // START, and a write carrying neither strobe leaves the timeout outcome
    // in place. A timeout keeps running only in continuous mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run <= 1'b0;
        end else if (wr_periodl || wr_periodh) begin
            run <= 1'b0;
        end else if (wr_control && ctrl_stop) begin
            run <= 1'b0;
        end else if (wr_control && ctrl_start) begin
            run <= 1'b1;
        end else if (timeout) begin
            run <= cont;
        end
    end

    // TO flag: a timeout sets it and outranks a same-cycle STATUS clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to <= 1'b0;
        end else if (timeout) begin
            to <= 1'b1;
        end else if (wr_status) begin
            to <= 1'b0;
        end
    end

    // Mode bits stored by a CONTROL write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cont <= 1'b0;
            ito  <= 1'b0;
        end else if (wr_control) begin
            cont <= bus.writedata[1];
            ito  <= bus.writedata[0];
        end
    end

`ifdef TIMER_SNAPSHOT_EN
    logic               wr_snap;
    logic [COUNT_W-1:0] snapshot;

    // A write to either snapshot address captures the live counter.
    always_comb begin
        wr_snap = wr && ((bus.address == ADDR_SNAPL) || (bus.address == ADDR_SNAPH));
        snap_lo = snapshot[15:0];
        snap_hi = 16'(snapshot[COUNT_W-1:16]);
    end

    // Snapshot register holds its value until the next capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snapshot <= '0;
        end else if (wr_snap) begin
            snapshot <= counter;
        end
    end
`else
    // No snapshot storage: both halves read as zero.
    always_comb begin
        snap_lo = 16'd0;
        snap_hi = 16'd0;
    end
`endif

    // Read multiplexer; unused upper bits and reserved addresses read 0.
    always_comb begin
        read_mux = 16'd0;
        case (bus.address)
            ADDR_STATUS:  read_mux = {14'd0, run, to};
            ADDR_CONTROL: read_mux = {14'd0, cont, ito};
            ADDR_PERIODL: read_mux = period[15:0];
            ADDR_PERIODH: read_mux = 16'(period[COUNT_W-1:16]);
            ADDR_SNAPL:   read_mux = snap_lo;
            ADDR_SNAPH:   read_mux = snap_hi;
            default:      read_mux = 16'd0;
        endcase
    end

    // Registered read data: follows the address with one cycle of latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= 16'd0;
        end else begin
            bus.readdata <= read_mux;
        end
    end

    // Level interrupt straight from the registered flags.
    assign bus.irq = to & ito;

endmodule

// File: tb/tb_param_interval_timer.sv
// tb_param_interval_timer -- directed checks for param_interval_timer.
// Inputs change 1 time unit after a rising edge. Outputs are sampled there
// too, so they are never read on the active edge.
module tb_param_interval_timer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] rd;
    int          checks = 0;
    int          errors = 0;

    param_interval_timer_if bus ();

    param_interval_timer #(
        .COUNT_W      (32),
        .RESET_PERIOD (32'd49999)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Clock: 10 time-unit period
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        bus.address = a;
        @(posedge clk);
        #1;
        d = bus.readdata;
    endtask

    initial begin
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 16'd0;

        // Reset
        #2 reset_n = 1'b0;
        #1;
        check("rst_readdata", 32'(bus.readdata), 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick(1);
        check("rst_counter", dut.counter, 32'd49999);
        check("rst_run", 32'(dut.run), 32'h0);
        bus_read(3'd2, rd); check("rst_periodl", 32'(rd), 32'hC34F);
        bus_read(3'd3, rd); check("rst_periodh", 32'(rd), 32'h0);
        bus_read(3'd0, rd); check("rst_status", 32'(rd), 32'h0);
        bus_read(3'd1, rd); check("rst_control", 32'(rd), 32'h0);

        // Continuous mode, PERIOD=4: timeout every 5 cycles
        bus_write(3'd2, 16'd4);
        bus_write(3'd3, 16'd0);
        bus_write(3'd1, 16'h0007);
        tick(4); check("cont_irq_early", 32'(bus.irq), 32'h0);
        tick(1); check("cont_irq_first", 32'(bus.irq), 32'h1);
        bus_write(3'd0, 16'd0);
        check("cont_irq_cleared", 32'(bus.irq), 32'h0);
        tick(3); check("cont_irq_gap", 32'(bus.irq), 32'h0);
        tick(1); check("cont_irq_second", 32'(bus.irq), 32'h1);
        bus_read(3'd0, rd); check("cont_status", 32'(rd), 32'h3);
        bus_write(3'd1, 16'h0008);
        check("stop_irq", 32'(bus.irq), 32'h0);

        // One-shot, PERIOD=9: single timeout after 10 cycles
        bus_write(3'd0, 16'd0);
        bus_write(3'd2, 16'd9);
        bus_write(3'd3, 16'd0);
        bus_write(3'd1, 16'h0004);
        bus.address = 3'd0;
        tick(10); check("oneshot_before", 32'(bus.readdata), 32'h2);
        tick(1);  check("oneshot_to", 32'(bus.readdata), 32'h1);
        tick(5);  check("oneshot_hold", 32'(bus.readdata), 32'h1);
        check("oneshot_counter", dut.counter, 32'd9);

        // TO clear versus coincident timeout, PERIOD=2 continuous
        bus_write(3'd0, 16'd0);
        bus_write(3'd2, 16'd2);
        bus_write(3'd3, 16'd0);
        bus_write(3'd1, 16'h0007);
        tick(2); check("p2_irq_early", 32'(bus.irq), 32'h0);
        tick(1); check("p2_irq_first", 32'(bus.irq), 32'h1);
        tick(2);
        bus_write(3'd0, 16'd0);
        check("to_priority", 32'(bus.irq), 32'h1);
        bus_write(3'd0, 16'd0);
        check("to_cleared", 32'(bus.irq), 32'h0);
        bus_read(3'd0, rd); check("to_cleared_status", 32'(rd), 32'h2);
        bus_write(3'd1, 16'h0008);
        bus_write(3'd0, 16'd0);
        bus_read(3'd0, rd); check("stop_status", 32'(rd), 32'h0);

        // START|STOP while idle: STOP wins, counter untouched
        bus_write(3'd1, 16'h000F);
        tick(3);
        check("startstop_counter", dut.counter, 32'd2);
        bus_read(3'd0, rd); check("startstop_status", 32'(rd), 32'h0);
        bus_read(3'd1, rd); check("control_readback", 32'(rd), 32'h3);
        check("startstop_irq", 32'(bus.irq), 32'h0);

        // PERIODH full width and reserved addresses
        bus_write(3'd3, 16'hABCD);
        bus_read(3'd3, rd); check("periodh_readback", 32'(rd), 32'hABCD);
        bus_read(3'd2, rd); check("periodl_readback", 32'(rd), 32'h2);
        bus_write(3'd6, 16'hFFFF);
        bus_read(3'd6, rd); check("reserved6", 32'(rd), 32'h0);
        bus_read(3'd7, rd); check("reserved7", 32'(rd), 32'h0);

        // Snapshot: PERIOD=0x0001_0003, capture while counter is 0x0001_0001
        bus_write(3'd2, 16'd3);
        bus_write(3'd3, 16'd1);
        bus_write(3'd1, 16'h0006);
        tick(2);
        bus_write(3'd4, 16'd0);
`ifdef TIMER_SNAPSHOT_EN
        bus_read(3'd4, rd); check("snapl", 32'(rd), 32'h0001);
        bus_read(3'd5, rd); check("snaph", 32'(rd), 32'h0001);
        tick(3);
        bus_read(3'd4, rd); check("snapl_hold", 32'(rd), 32'h0001);
`else
        bus_read(3'd4, rd); check("snapl_off", 32'(rd), 32'h0);
        bus_read(3'd5, rd); check("snaph_off", 32'(rd), 32'h0);
`endif

        // Reset mid-count with irq high, PERIOD=4 continuous
        bus_write(3'd2, 16'd4);
        bus_write(3'd3, 16'd0);
        bus_write(3'd1, 16'h0007);
        tick(5); check("pre_reset_irq", 32'(bus.irq), 32'h1);
        bus.address = 3'd0;
        tick(1); check("pre_reset_status", 32'(bus.readdata), 32'h3);
        #1 reset_n = 1'b0;
        #1;
        check("async_irq", 32'(bus.irq), 32'h0);
        check("async_readdata", 32'(bus.readdata), 32'h0);
        check("async_run", 32'(dut.run), 32'h0);
        check("async_counter", dut.counter, 32'd49999);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick(5);
        check("idle_counter", dut.counter, 32'd49999);
        bus_read(3'd0, rd); check("idle_status", 32'(rd), 32'h0);
        bus_read(3'd1, rd); check("idle_control", 32'(rd), 32'h0);
        bus_read(3'd2, rd); check("idle_periodl", 32'(rd), 32'hC34F);
        bus_write(3'd1, 16'h0004);
        check("start_no_dec", dut.counter, 32'd49999);
        tick(1);
        check("first_dec", dut.counter, 32'd49998);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
